// File: rtl/sdram_master_pkg.sv
// Shared state encoding, constants and burst sizing helper for the SDRAM local-interface master.
package sdram_master_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle    = 3'd0;
   localparam state_t StWr      = 3'd1;
   localparam state_t StRd      = 3'd2;
   localparam state_t StRdDrain = 3'd3;
   localparam state_t StDone    = 3'd4;

   localparam logic [3:0] BE_ALL = 4'hF;

   // Length of the next burst: the smaller of what is left and the burst cap.
   function automatic logic [2:0] burst_len(input int unsigned remaining,
                                            input int unsigned max_burst);
      if (remaining < max_burst) begin
         return 3'(remaining);
      end
      return 3'(max_burst);
   endfunction

endpackage

// File: rtl/sdram_rd_credit.sv
// Outstanding read-beat counter: beats requested from the controller but not yet returned.
module sdram_rd_credit #(
   parameter int unsigned MAX_OUTSTANDING = 16,
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue,
   input  logic [2:0]    size,
   input  logic          rtn,
   input  logic [2:0]    want,
   output logic [CW-1:0] count,
   output logic          can_issue
);

   logic [CW-1:0] count_q, count_d;
   logic [CW:0]   sum;

   always_comb begin
      count_d = count_q;
      if (issue) begin
         count_d = count_d + CW'(size);
      end
      // A return with nothing outstanding is stray data and must not wrap the count.
      if (rtn && (count_q != '0)) begin
         count_d = count_d - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign sum       = {1'b0, count_q} + (CW + 1)'(want);
   assign can_issue = (sum <= (CW + 1)'(MAX_OUTSTANDING));
   assign count     = count_q;

endmodule

// File: rtl/sdram_local_master.sv
// Command-driven burst initiator for the SDRAM controller local interface: splits write and
// read commands into bursts, paces reads by outstanding-beat credit, registers read returns.
module sdram_local_master
   import sdram_master_pkg::*;
#(
   parameter int unsigned ADDR_W          = 23,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned LEN_W           = 16,
   parameter int unsigned MAX_BURST       = 4,
   parameter int unsigned MAX_OUTSTANDING = 16
) (
   input  logic              phy_clk,
   input  logic              reset_phy_clk_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   input  logic              local_init_done,
   input  logic              local_ready,
   input  logic [DATA_W-1:0] local_rdata,
   input  logic              local_rdata_valid,
   output logic [ADDR_W-1:0] local_address,
   output logic [2:0]        local_size,
   output logic              local_burstbegin,
   output logic              local_write_req,
   output logic              local_read_req,
   output logic [DATA_W-1:0] local_wdata,
   output logic [3:0]        local_be
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [2:0]          blen_q, blen_d;
   logic [2:0]          beat_q, beat_d;
   logic [DATA_W-1:0]   rd_data_q;
   logic                rd_valid_q;
   logic [CW-1:0]       out_cnt;
   logic                can_issue;

   sdram_rd_credit #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_rd_credit (
      .clk       (phy_clk),
      .rst_n     (reset_phy_clk_n),
      .issue     (local_read_req & local_ready),
      .size      (blen_q),
      .rtn       (local_rdata_valid),
      .want      (blen_q),
      .count     (out_cnt),
      .can_issue (can_issue)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      rem_d            = rem_q;
      blen_d           = blen_q;
      beat_d           = beat_q;
      cmd_ready        = 1'b0;
      wr_ready         = 1'b0;
      local_write_req  = 1'b0;
      local_read_req   = 1'b0;
      local_burstbegin = 1'b0;
      local_address    = '0;
      local_size       = '0;
      local_wdata      = '0;
      unique case (state_q)
         StIdle: begin
            // Gated by reset so the handshake is dead while reset is held.
            cmd_ready = local_init_done & reset_phy_clk_n;
            if (cmd_valid && cmd_ready) begin
               addr_d = cmd_addr;
               rem_d  = cmd_len;
               blen_d = burst_len(32'(cmd_len), MAX_BURST);
               beat_d = '0;
               if (cmd_len == '0) begin
                  state_d = StDone;
               end else if (cmd_write) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StWr: begin
            local_address    = addr_q;
            local_size       = blen_q;
            local_wdata      = wr_data;
            local_write_req  = wr_valid;
            local_burstbegin = wr_valid & (beat_q == '0);
            wr_ready         = local_ready;
            if (wr_valid && local_ready) begin
               if (beat_q == (blen_q - 3'd1)) begin
                  beat_d = '0;
                  addr_d = addr_q + ADDR_W'(blen_q);
                  rem_d  = rem_q - LEN_W'(blen_q);
                  blen_d = burst_len(32'(rem_d), MAX_BURST);
                  if (rem_d == '0) begin
                     state_d = StDone;
                  end
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         StRd: begin
            local_address    = addr_q;
            local_size       = blen_q;
            local_read_req   = can_issue;
            local_burstbegin = can_issue;
            if (can_issue && local_ready) begin
               addr_d = addr_q + ADDR_W'(blen_q);
               rem_d  = rem_q - LEN_W'(blen_q);
               blen_d = burst_len(32'(rem_d), MAX_BURST);
               if (rem_d == '0) begin
                  state_d = StRdDrain;
               end
            end
         end
         StRdDrain: begin
            // Leave one cycle early on the final return so done lines up with the last rd_valid.
            if ((out_cnt == '0) || ((out_cnt == CW'(1)) && local_rdata_valid)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         blen_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         blen_q  <= blen_d;
         beat_q  <= beat_d;
      end
   end

   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= local_rdata_valid & (out_cnt != '0);
         if (local_rdata_valid && (out_cnt != '0)) begin
            rd_data_q <= local_rdata;
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign local_be = BE_ALL;

endmodule
